// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - Round-robin arbiter over 32 requests with registered winner index and valid/ready handshake
module rr_index_arbiter #(
    parameter int N_REQ = 32,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] ptr,
    output logic [CNT_W-1:0] grant_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               valid_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic [IDX_W-1:0]   ptr_nx;
    logic [CNT_W-1:0]   cnt_nx;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W-1:0]   winner;
    logic               any_req;

    // Rotate the request vector so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[{1'b0, ptr} +: N_REQ];
        any_req = |req;
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
        winner = ptr + offset;
    end

    // Next-state and next-output logic; grant is held until accepted, then a one-cycle bubble.
    always_comb begin
        state_nx = state;
        valid_nx = grant_valid;
        idx_nx   = grant_idx;
        ptr_nx   = ptr;
        cnt_nx   = grant_count;
        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                if (en && any_req) begin
                    idx_nx   = winner;
                    valid_nx = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (grant_ready) begin
                    ptr_nx   = grant_idx + IDX_W'(1);
                    cnt_nx   = grant_count + CNT_W'(1);
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= '0;
            grant_count <= '0;
        end else begin
            state       <= state_nx;
            grant_valid <= valid_nx;
            grant_idx   <= idx_nx;
            ptr         <= ptr_nx;
            grant_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb/tb_rr_index_arbiter.sv - Self-checking scoreboard bench for rr_index_arbiter
module tb_rr_index_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] req;
    logic        grant_ready;
    logic        grant_valid;
    logic [4:0]  grant_idx;
    logic [4:0]  ptr;
    logic [15:0] grant_count;

    logic        s_en;
    logic [31:0] s_req;
    logic        s_ready;
    logic        s_valid;
    logic [4:0]  s_idx;
    logic [4:0]  s_ptr;
    logic [3:0]  s_count;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];

    rr_index_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr         (ptr),
        .grant_count (grant_count)
    );

    rr_index_arbiter #(.CNT_W(4)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .en          (s_en),
        .req         (s_req),
        .grant_ready (s_ready),
        .grant_valid (s_valid),
        .grant_idx   (s_idx),
        .ptr         (s_ptr),
        .grant_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0; req = '0; grant_ready = 1'b0;
        s_en = 1'b0; s_req = '0; s_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n = c + 1;
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 5'd0 || ptr !== 5'd0 || grant_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: valid=%0b idx=%0d ptr=%0d count=%0d, required 0 0 0 0",
                     grant_valid, grant_idx, ptr, grant_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok; int n; int e;
        do_reset();
        req = 32'h0000_0010; en = 1'b1; grant_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(4);
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || grant_idx !== 5'(e) || n !== 1) begin
                fails++;
                $display("FAIL single_grant[%0d]: ok=%0b idx=%0d latency=%0d, required idx=%0d latency=1",
                         k, ok, grant_idx, n, e);
            end
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b0 || ptr !== 5'd5 || grant_count !== 16'(k + 1)) begin
                fails++;
                $display("FAIL single_handshake[%0d]: valid=%0b ptr=%0d count=%0d, required 0 5 %0d",
                         k, grant_valid, ptr, grant_count, k + 1);
            end
        end
    endtask

    task automatic test_rotation();
        bit ok; int n; int e;
        do_reset();
        req = 32'hFFFF_FFFF; en = 1'b1; grant_ready = 1'b1;
        for (int k = 0; k < 64; k++) exp_q.push_back(k % 32);
        for (int k = 0; k < 64; k++) begin
            wait_valid(ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || grant_idx !== 5'(e)) begin
                fails++;
                $display("FAIL rotation_idx[%0d]: ok=%0b idx=%0d, required %0d", k, ok, grant_idx, e);
            end
            @(negedge clk);
            checks++;
            if (ptr !== 5'((e + 1) % 32)) begin
                fails++;
                $display("FAIL rotation_ptr[%0d]: ptr=%0d, required %0d", k, ptr, (e + 1) % 32);
            end
        end
        checks++;
        if (grant_count !== 16'd64) begin
            fails++;
            $display("FAIL rotation_count: count=%0d, required 64", grant_count);
        end
    endtask

    task automatic test_fairness();
        bit ok; int n; int e;
        do_reset();
        req = 32'h2000_0000; en = 1'b1; grant_ready = 1'b1;
        wait_valid(ok, n);
        @(negedge clk);
        checks++;
        if (!ok || ptr !== 5'd30) begin
            fails++;
            $display("FAIL fairness_setup: ok=%0b ptr=%0d, required ptr=30", ok, ptr);
        end
        req = 32'h8000_0003;
        exp_q.push_back(31); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(31);
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || grant_idx !== 5'(e)) begin
                fails++;
                $display("FAIL fairness_idx[%0d]: ok=%0b idx=%0d, required %0d", k, ok, grant_idx, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int n; int e;
        do_reset();
        req = 32'h0000_0200; en = 1'b1; grant_ready = 1'b0;
        exp_q.push_back(9);
        wait_valid(ok, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || grant_idx !== 5'(e)) begin
            fails++;
            $display("FAIL backpressure_grant: ok=%0b idx=%0d, required %0d", ok, grant_idx, e);
        end
        req = '0; en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 5'd9) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: valid=%0b idx=%0d, required 1 9", k, grant_valid, grant_idx);
            end
        end
        grant_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant_count !== 16'd1 || ptr !== 5'd10) begin
            fails++;
            $display("FAIL backpressure_release: valid=%0b count=%0d ptr=%0d, required 0 1 10",
                     grant_valid, grant_count, ptr);
        end
        req = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (grant_valid !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_en_low[%0d]: valid=%0b, required 0", k, grant_valid);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok; int n; int e;
        do_reset();
        req = 32'h0000_0080; en = 1'b1; grant_ready = 1'b1;
        wait_valid(ok, n);
        @(negedge clk);
        grant_ready = 1'b0;
        exp_q.push_back(7);
        wait_valid(ok, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || grant_idx !== 5'(e) || ptr !== 5'd8 || grant_count !== 16'd1) begin
            fails++;
            $display("FAIL midhold_setup: ok=%0b idx=%0d ptr=%0d count=%0d, required 7 8 1",
                     ok, grant_idx, ptr, grant_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 5'd0 || ptr !== 5'd0 || grant_count !== 16'd0) begin
            fails++;
            $display("FAIL midhold_async_reset: valid=%0b idx=%0d ptr=%0d count=%0d, required 0 0 0 0",
                     grant_valid, grant_idx, ptr, grant_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_count_wrap();
        bit ok;
        int model;
        do_reset();
        s_req = 32'hFFFF_FFFF; s_en = 1'b1; s_ready = 1'b1;
        model = 0;
        for (int k = 0; k < 17; k++) begin
            ok = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (s_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(negedge clk);
            model = (model + 1) % 16;
            checks++;
            if (!ok || s_count !== 4'(model)) begin
                fails++;
                $display("FAIL count_wrap[%0d]: ok=%0b count=%0d, required %0d", k, ok, s_count, model);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; req = '0; grant_ready = 1'b0;
        s_en = 1'b0; s_req = '0; s_ready = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_fairness();
        test_backpressure();
        test_reset_mid_hold();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
